// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: control-word bit positions and the bubble control word.
package riscv_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[2:0]} word
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 3;
  localparam int CTRL_ALU_OP     = 0;
  localparam int CTRL_ALU_OP_W   = 3;

  // A bubble writes nothing and touches no memory, so forwarding and hazard logic never match it
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector and PC / IF-ID write enables.
module hazard_detect (
  input  logic       id_ex_valid,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       hold,
  input  logic       flush,
  output logic       lu,
  output logic       pc_write,
  output logic       if_id_write
);

  // A load in EX whose result the decode instruction actually reads; x0 never hazards.
  // A flush kills the instruction anyway, so it cancels the stall.
  always_comb begin
    lu = id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0) & id_valid &
         ((id_use_rs1 & (id_rs1 == id_ex_rd)) | (id_use_rs2 & (id_rs2 == id_ex_rd)));
    pc_write    = ~(hold | (lu & ~flush));
    if_id_write = pc_write;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, WB bypass
// and saturating bubble/flush counters.
//
// Flow control: id_valid marks a real instruction in decode; the slot advances on every
// edge where hold=0. hold=1 freezes this stage entirely (flush and hazards are ignored).
// When pc_write/if_id_write are 0 upstream must keep the same decode instruction presented.
module id_ex_stage_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rs1_data,
  output logic [XLEN-1:0]   id_ex_rs2_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic [4:0]        id_ex_rd,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic            lu;
  logic [XLEN-1:0] rs1_data_byp;
  logic [XLEN-1:0] rs2_data_byp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard_detect (
    .id_ex_valid    (id_ex_valid),
    .id_ex_mem_read (id_ex_ctrl[CTRL_MEM_READ]),
    .id_ex_rd       (id_ex_rd),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .hold           (hold),
    .flush          (flush),
    .lu             (lu),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write)
  );

  // WB writes the regfile in the same cycle decode reads it, so take the WB value directly
  always_comb begin
    rs1_data_byp = id_rs1_data;
    rs2_data_byp = id_rs2_data;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) rs1_data_byp = wb_data;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) rs2_data_byp = wb_data;
  end

  // Stage register: hold > flush > load-use bubble > normal latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_ctrl     <= CTRL_NOP;
      bubble_cnt     <= '0;
      flush_cnt      <= '0;
    end else if (hold) begin
      // frozen: keep everything
    end else if (flush || lu) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_ctrl     <= CTRL_NOP;
      if (flush) flush_cnt  <= sat_inc(flush_cnt);
      else       bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      id_ex_valid    <= id_valid;
      id_ex_pc       <= id_pc;
      id_ex_rs1_data <= rs1_data_byp;
      id_ex_rs2_data <= rs2_data_byp;
      id_ex_imm      <= id_imm;
      id_ex_rs1      <= id_rs1;
      id_ex_rs2      <= id_rs2;
      id_ex_rd       <= id_rd;
      id_ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg.
module tb_id_ex_stage_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [9:0] C_LW  = 10'h360; // reg_write|mem_read|mem_to_reg|alu_src
  localparam logic [9:0] C_ADD = 10'h200; // reg_write only

  logic             clk;
  logic             rst_n;
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [9:0]       id_ctrl;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             id_ex_valid;
  logic [XLEN-1:0]  id_ex_pc;
  logic [XLEN-1:0]  id_ex_rs1_data;
  logic [XLEN-1:0]  id_ex_rs2_data;
  logic [XLEN-1:0]  id_ex_imm;
  logic [4:0]       id_ex_rs1;
  logic [4:0]       id_ex_rs2;
  logic [4:0]       id_ex_rd;
  logic [9:0]       id_ex_ctrl;
  logic             pc_write;
  logic             if_id_write;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_total;
  int n_bad;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hold           (hold),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_ctrl        (id_ctrl),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .id_ex_valid    (id_ex_valid),
    .id_ex_pc       (id_ex_pc),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_imm      (id_ex_imm),
    .id_ex_rs1      (id_ex_rs1),
    .id_ex_rs2      (id_ex_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_ctrl     (id_ex_ctrl),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .bubble_cnt     (bubble_cnt),
    .flush_cnt      (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a decode instruction; register data derived from the indices
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic [9:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_ctrl     = ctrl;
    id_rs1_data = 32'hA000_0000 | 32'(rs1);
    id_rs2_data = 32'hB000_0000 | 32'(rs2);
    id_imm      = pc + 32'h10;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 10'h0);

    // 1. reset with random decode inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            10'($urandom_range(0, 1023)));
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom;
      tick();
    end
    check("rst_valid", 64'(id_ex_valid), 64'd0);
    check("rst_pc", 64'(id_ex_pc), 64'd0);
    check("rst_rs1_data", 64'(id_ex_rs1_data), 64'd0);
    check("rst_rs2_data", 64'(id_ex_rs2_data), 64'd0);
    check("rst_imm", 64'(id_ex_imm), 64'd0);
    check("rst_tags", 64'({id_ex_rs1, id_ex_rs2, id_ex_rd}), 64'd0);
    check("rst_ctrl", 64'(id_ex_ctrl), 64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rst_pc_write", 64'(pc_write), 64'd1);
    check("rst_if_id_write", 64'(if_id_write), 64'd1);
    rst_n = 1'b1;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

    // 2. load-use: lw x5 then add x8,x5,x6
    drive(1'b1, 32'h100, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
    tick();
    check("lw_rd", 64'(id_ex_rd), 64'd5);
    check("lw_ctrl", 64'(id_ex_ctrl), 64'(C_LW));
    check("lw_valid", 64'(id_ex_valid), 64'd1);
    drive(1'b1, 32'h104, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, C_ADD);
    check("lu_pc_write", 64'(pc_write), 64'd0);
    check("lu_if_id_write", 64'(if_id_write), 64'd0);
    tick();
    check("bub_valid", 64'(id_ex_valid), 64'd0);
    check("bub_ctrl", 64'(id_ex_ctrl), 64'd0);
    check("bub_rd", 64'(id_ex_rd), 64'd0);
    check("bub_cnt1", 64'(bubble_cnt), 64'd1);
    check("bub_pc_write", 64'(pc_write), 64'd1);
    tick();
    check("add_valid", 64'(id_ex_valid), 64'd1);
    check("add_pc", 64'(id_ex_pc), 64'h104);
    check("add_rs1", 64'(id_ex_rs1), 64'd5);
    check("add_rs2", 64'(id_ex_rs2), 64'd6);
    check("add_rd", 64'(id_ex_rd), 64'd8);
    check("add_rs1_data", 64'(id_ex_rs1_data), 64'hA000_0005);
    check("add_rs2_data", 64'(id_ex_rs2_data), 64'hB000_0006);
    check("add_imm", 64'(id_ex_imm), 64'h114);
    check("add_ctrl", 64'(id_ex_ctrl), 64'(C_ADD));
    check("add_bub_cnt", 64'(bubble_cnt), 64'd1);

    // 3. no false hazards
    drive(1'b1, 32'h108, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, C_LW);
    tick();
    drive(1'b1, 32'h10C, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
    check("rd0_pc_write", 64'(pc_write), 64'd1);
    tick();
    check("rd0_next_valid", 64'(id_ex_valid), 64'd1);
    check("rd0_next_rd", 64'(id_ex_rd), 64'd5);
    drive(1'b1, 32'h110, 5'd3, 1'b1, 5'd5, 1'b0, 5'd9, C_ADD);
    check("nouse_pc_write", 64'(pc_write), 64'd1);
    tick();
    check("nouse_valid", 64'(id_ex_valid), 64'd1);
    check("nouse_rd", 64'(id_ex_rd), 64'd9);
    check("nouse_bub_cnt", 64'(bubble_cnt), 64'd1);

    // 4. flush and load-use in the same cycle
    drive(1'b1, 32'h114, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h118, 5'd5, 1'b1, 5'd0, 1'b0, 5'd4, C_ADD);
    flush = 1'b1;
    #1;
    check("fl_lu_pc_write", 64'(pc_write), 64'd1);
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(id_ex_valid), 64'd0);
    check("fl_ctrl", 64'(id_ex_ctrl), 64'd0);
    check("fl_flush_cnt", 64'(flush_cnt), 64'd1);
    check("fl_bub_cnt", 64'(bubble_cnt), 64'd1);

    // 5. hold freezes the stage; flush during hold ignored
    drive(1'b1, 32'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, C_ADD);
    tick();
    check("pre_hold_pc", 64'(id_ex_pc), 64'h200);
    hold  = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 5'(11 + i), 1'b1, 5'(20 + i), 1'b1, 5'(12 + i), C_LW);
      check("hold_pc_write", 64'(pc_write), 64'd0);
      tick();
      flush = 1'b0;
      check("hold_pc", 64'(id_ex_pc), 64'h200);
      check("hold_rd", 64'(id_ex_rd), 64'd10);
      check("hold_ctrl", 64'(id_ex_ctrl), 64'(C_ADD));
      check("hold_valid", 64'(id_ex_valid), 64'd1);
      check("hold_flush_cnt", 64'(flush_cnt), 64'd1);
    end
    hold = 1'b0;

    // 6. WB bypass
    drive(1'b1, 32'h400, 5'd1, 1'b1, 5'd7, 1'b1, 5'd3, C_ADD);
    id_rs2_data = 32'h0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick();
    check("byp_rs2_data", 64'(id_ex_rs2_data), 64'hDEAD_BEEF);
    check("byp_rs1_data", 64'(id_ex_rs1_data), 64'hA000_0001);
    drive(1'b1, 32'h404, 5'd1, 1'b1, 5'd0, 1'b1, 5'd3, C_ADD);
    id_rs2_data = 32'h0;
    wb_rd = 5'd0;
    tick();
    check("byp_x0_data", 64'(id_ex_rs2_data), 64'd0);
    wb_reg_write = 1'b0;

    // invalid decode slot latches a zeroed control word
    drive(1'b0, 32'h408, 5'd1, 1'b0, 5'd2, 1'b0, 5'd6, 10'h3FF);
    tick();
    check("inv_valid", 64'(id_ex_valid), 64'd0);
    check("inv_ctrl", 64'(id_ex_ctrl), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
